mips_cpu_bus_memory: RTL and testbench
======================================

Name: mips_cpu_bus_memory

Overview:
- Synthesisable Avalon memory-mapped responder (slave) for the CPU's bus controller port.
- Word-organised RAM window with byte-enabled writes and a programmable wait-state count driven via waitrequest.
- Used as instruction/data memory in system-level benches and FPGA builds; it answers mem_address/memread/memwrite/memwritedata/byteenable and returns memreaddata/waitrequest.

Parameters:
- BASE_ADDR, 32'hBFC00000, byte address of word 0 of the window.
- DEPTH_LOG2, 10, log2 of the number of 32-bit words (1024 words).
- WAIT_CYCLES, 1, number of stall cycles per transfer; legal range 1..15.
- INIT_FILE, "", hex image loaded by $readmemh at elaboration; empty means no load.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_address  input  32  byte address from the bus controller.
- memread  input  1  read request.
- memwrite  input  1  write request.
- memwritedata  input  32  write data.
- byteenable  input  4  byte lane enables; bit i qualifies bits [8i+7:8i].
- waitrequest  output  1  high = transfer not yet accepted; master holds all inputs stable.
- memreaddata  output  32  read data; valid in the cycle a read completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wait counter=0, memreaddata=0.
  - waitrequest follows the combinational rule below, so it is high during reset whenever a request is present.
  - RAM contents are not cleared by reset.
- Address decode:
  - offset = mem_address - BASE_ADDR (32-bit wrap).
  - Hit when offset[31:2] < 2**DEPTH_LOG2; index = offset[DEPTH_LOG2+1:2].
  - offset[1:0] is ignored; there is no misalignment fault.
- State machine (IDLE, WAIT, READY):
  - IDLE: on a request (memread|memwrite), go to WAIT with counter=1.
  - WAIT: counter increments each cycle. When counter==WAIT_CYCLES, go to READY and register memreaddata <= RAM[index], or 0 on a miss or a write.
  - READY: at the clock edge, the transfer completes. A write commits RAM[index] lanes where byteenable[i]=1 (hit only; a miss is silently dropped). Return to IDLE.
- waitrequest = (memread|memwrite) && state!=READY, purely combinational.
  - A request sees exactly WAIT_CYCLES+1 cycles of waitrequest=1 (IDLE cycle plus WAIT cycles), then one cycle of waitrequest=0.
  - Total latency from request to completion is WAIT_CYCLES+2 cycles.
- memreaddata holds its last value until the next READY entry. It is not cleared between transfers.
- Back-to-back requests:
  - If a request is still asserted in the cycle after completion, it is a new transfer: IDLE then WAIT.
  - This gives at most one transfer per WAIT_CYCLES+2 cycles.
- memread and memwrite high together: treated as a write; memreaddata loads 0.
- Request dropped while in WAIT or READY (protocol violation): return to IDLE next edge, no RAM write, memreaddata unchanged.
- Reset asserted mid-transfer: abort immediately, no write commits, memreaddata=0.
- byteenable=4'b0000 write: completes normally with no RAM change.
- Implementation: the RAM is a single inferred array with one read/write port. Read-during-write cannot occur because only one transfer is in flight.

Test Plan:
- Reset: hold reset=0 with memread=1 -> memreaddata=0, waitrequest=1. Release -> first completion occurs WAIT_CYCLES+2 cycles later.
- Full write then read, WAIT_CYCLES=2:
  - Write 32'hDEADBEEF to 32'hBFC00010, byteenable=4'hF -> waitrequest high for exactly 3 cycles, low for 1.
  - Read same address -> memreaddata=32'hDEADBEEF in the waitrequest-low cycle.
- Partial write:
  - Preload 32'h11223344 at 32'hBFC00020, then write 32'hAABBCCDD with byteenable=4'b0101.
  - Read back -> 32'h11BB33DD.
- Out-of-range:
  - Write 32'h12345678 to 32'h00000000 -> completes, RAM unchanged.
  - Read 32'h00000000 -> 32'h00000000.
  - Read BASE_ADDR+4*1024 -> 0.
- Back-to-back reads, WAIT_CYCLES=1: hold memread=1 while changing the address only after each waitrequest-low cycle -> one completion every 3 cycles, correct data for each.
- Reset mid-write, WAIT_CYCLES=3:
  - Assert reset=0 during the second WAIT cycle of a write of 32'hCAFEF00D.
  - Read afterwards -> old contents unchanged; memreaddata=0 during reset.

Source files
------------

// File: rtl/mips_cpu_bus_memory_if.sv
// Avalon-MM bus bundle between the CPU bus controller (master) and a
// memory responder (slave).
interface mips_cpu_bus_memory_if;
   logic [31:0] mem_address;
   logic        memread;
   logic        memwrite;
   logic [31:0] memwritedata;
   logic [3:0]  byteenable;
   logic        waitrequest;
   logic [31:0] memreaddata;

   modport master (
      output mem_address, memread, memwrite, memwritedata, byteenable,
      input  waitrequest, memreaddata
   );

   modport slave (
      input  mem_address, memread, memwrite, memwritedata, byteenable,
      output waitrequest, memreaddata
   );
endinterface

// File: rtl/mips_cpu_bus_memory.sv
// Avalon-MM memory responder: a word-organised RAM window at BASE_ADDR with
// byte-lane writes and a fixed number of wait states per transfer.
// Each request spends one IDLE cycle plus WAIT_CYCLES wait cycles with
// waitrequest high, then one READY cycle with waitrequest low.
module mips_cpu_bus_memory #(
   parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
   parameter int unsigned DEPTH_LOG2  = 10,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter string       INIT_FILE   = ""
) (
   input  logic                          clk,
   input  logic                          reset,
   mips_cpu_bus_memory_if.slave          bus
);

   localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_READY = 2'd2
   } state_t;

   state_t                  state, state_next;
   logic [3:0]              cnt, cnt_next;
   logic                    req;
   logic                    load_rdata;
   logic                    commit;
   logic [31:0]             offset;
   logic                    hit;
   logic [DEPTH_LOG2-1:0]   index;
   logic [31:0]             rdata_value;
   logic [31:0]             ram [DEPTH];

   // Byte offset within a word is deliberately ignored: no misalignment fault.
   logic unused_byte_offset;
   assign unused_byte_offset = ^offset[1:0];

   // Address decode relative to the window base; subtraction wraps at 32 bits.
   assign offset = bus.mem_address - BASE_ADDR;
   assign hit    = (offset[31:DEPTH_LOG2+2] == '0);
   assign index  = offset[DEPTH_LOG2+1:2];
   assign req    = bus.memread | bus.memwrite;

   // State register and wait counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every flop samples the
         // pre-edge values of its inputs, independent of process order.
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state logic; a dropped request always falls back to IDLE.
   always_comb begin
      // NOTE: defaults first so every path assigns every output; a missing
      // branch would otherwise infer a latch.
      state_next = state;
      cnt_next   = cnt;
      case (state)
         ST_IDLE: begin
            if (req) begin
               state_next = ST_WAIT;
               cnt_next   = 4'd1;
            end
         end
         ST_WAIT: begin
            if (!req) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else if (cnt == WAIT_LAST) begin
               state_next = ST_READY;
            end else begin
               cnt_next = cnt + 4'd1;
            end
         end
         ST_READY: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Outputs and strobes decoded from the current state.
   always_comb begin
      bus.waitrequest = req && (state != ST_READY);
      load_rdata      = (state == ST_WAIT) && req && (cnt == WAIT_LAST);
      commit          = (state == ST_READY) && bus.memwrite && hit;
      // A write (including read+write together) or a miss returns zero.
      rdata_value     = (hit && !bus.memwrite) ? ram[index] : 32'h0;
   end

   // Read data register: loaded on READY entry, held otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.memreaddata <= 32'h0;
      end else if (load_rdata) begin
         bus.memreaddata <= rdata_value;
      end
   end

   // Byte-lane write port; commits only in the READY cycle of a hit.
   // NOTE: the RAM array has no reset so it maps onto block RAM and keeps
   // its contents across a reset pulse.
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.byteenable[i]) begin
               ram[index][8*i +: 8] <= bus.memwritedata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_mips_cpu_bus_memory.sv
// Scoreboard bench for mips_cpu_bus_memory: three instances with
// WAIT_CYCLES = 1, 2, 3 share one stimulus bus; only the selected instance
// sees a request. Expected responses are queued at issue time and popped by
// a monitor whenever an instance completes a transfer.
module tb_mips_cpu_bus_memory;

   localparam logic [31:0] BASE = 32'hBFC00000;

   logic        clk = 1'b0;
   logic        rst;
   int          sel;
   logic        rd, wr;
   logic [31:0] addr, wdata;
   logic [3:0]  be;

   always #5 clk = ~clk;

   mips_cpu_bus_memory_if bus0 ();
   mips_cpu_bus_memory_if bus1 ();
   mips_cpu_bus_memory_if bus2 ();

   logic [2:0]  req;
   logic [2:0]  wq;
   logic [31:0] rdq [3];

   assign req[0] = (rd | wr) && (sel == 0);
   assign req[1] = (rd | wr) && (sel == 1);
   assign req[2] = (rd | wr) && (sel == 2);

   assign bus0.mem_address = addr;  assign bus0.memwritedata = wdata;  assign bus0.byteenable = be;
   assign bus1.mem_address = addr;  assign bus1.memwritedata = wdata;  assign bus1.byteenable = be;
   assign bus2.mem_address = addr;  assign bus2.memwritedata = wdata;  assign bus2.byteenable = be;
   assign bus0.memread  = rd && (sel == 0);  assign bus0.memwrite = wr && (sel == 0);
   assign bus1.memread  = rd && (sel == 1);  assign bus1.memwrite = wr && (sel == 1);
   assign bus2.memread  = rd && (sel == 2);  assign bus2.memwrite = wr && (sel == 2);

   assign wq[0] = bus0.waitrequest;  assign rdq[0] = bus0.memreaddata;
   assign wq[1] = bus1.waitrequest;  assign rdq[1] = bus1.memreaddata;
   assign wq[2] = bus2.waitrequest;  assign rdq[2] = bus2.memreaddata;

   mips_cpu_bus_memory #(.WAIT_CYCLES(1)) dut0 (.clk(clk), .reset(rst), .bus(bus0));
   mips_cpu_bus_memory #(.WAIT_CYCLES(2)) dut1 (.clk(clk), .reset(rst), .bus(bus1));
   mips_cpu_bus_memory #(.WAIT_CYCLES(3)) dut2 (.clk(clk), .reset(rst), .bus(bus2));

   typedef struct {
      int          inst;
      logic [31:0] data;
      int          hi;
   } exp_t;

   exp_t q[$];
   int   vectors    = 0;
   int   miscompares = 0;
   int   wc [3] = '{1, 2, 3};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, want);
      end
   endtask

   // Monitor: counts waitrequest-high cycles per request and scores each
   // completion (request present, waitrequest low) against the queue.
   int   hi [3] = '{0, 0, 0};
   exp_t e;
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst || !req[k]) begin
            hi[k] = 0;
         end else if (wq[k]) begin
            hi[k]++;
         end else begin
            if (q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_completion: instance %0d completed with nothing queued", k);
            end else begin
               e = q.pop_front();
               check($sformatf("inst%0d_which", k), 32'(k), 32'(e.inst));
               check($sformatf("inst%0d_rdata", k), rdq[k], e.data);
               check($sformatf("inst%0d_wait_hi", k), 32'(hi[k]), 32'(e.hi));
            end
            hi[k] = 0;
         end
      end
   end

   task automatic issue(input int s, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, input logic [31:0] expd);
      exp_t x;
      x.inst = s;
      x.data = expd;
      x.hi   = wc[s] + 1;
      q.push_back(x);
      sel = s; addr = a; wdata = d; be = b; rd = r; wr = w;
   endtask

   task automatic wait_done(input int s, input bit hold);
      bit done = 1'b0;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         if (!wq[s]) done = 1'b1;
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout: instance %0d never dropped waitrequest, expected within 64 cycles", s);
      end
      @(posedge clk);
      #1;
      if (!hold) begin
         rd = 1'b0;
         wr = 1'b0;
      end
   endtask

   task automatic xfer(input int s, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic [31:0] expd,
                       input bit hold);
      issue(s, r, w, a, d, b, expd);
      wait_done(s, hold);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, expected completion well before 1 ms");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; sel = 0; rd = 1'b0; wr = 1'b0;
      addr = '0; wdata = '0; be = 4'h0;
      repeat (3) @(posedge clk);
      #1;

      // Reset with a read pending: zero data, waitrequest held high.
      sel = 0; rd = 1'b1; addr = 32'h0;
      @(negedge clk);
      check("reset_rdata", rdq[0], 32'h0);
      check("reset_waitrequest", 32'(wq[0]), 32'h1);
      issue(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      wait_done(0, 1'b0);

      // WAIT_CYCLES=2: full write then read.
      xfer(1, 0, 1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0);
      xfer(1, 1, 0, BASE + 32'h10, 32'h0,        4'hF, 32'hDEADBEEF, 0);
      // Low address bits ignored.
      xfer(1, 1, 0, BASE + 32'h13, 32'h0,        4'hF, 32'hDEADBEEF, 0);

      // Partial write, then an all-lanes-off write that changes nothing.
      xfer(1, 0, 1, BASE + 32'h20, 32'h11223344, 4'hF,    32'h0, 0);
      xfer(1, 0, 1, BASE + 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 0);
      xfer(1, 1, 0, BASE + 32'h20, 32'h0,        4'hF,    32'h11BB33DD, 0);
      xfer(1, 0, 1, BASE + 32'h20, 32'hFFFFFFFF, 4'b0000, 32'h0, 0);
      xfer(1, 1, 0, BASE + 32'h20, 32'h0,        4'hF,    32'h11BB33DD, 0);

      // Out-of-range accesses: word 0 must survive a miss that aliases onto it.
      xfer(1, 0, 1, BASE,          32'h55AA55AA, 4'hF, 32'h0, 0);
      xfer(1, 0, 1, 32'h00000000,  32'h12345678, 4'hF, 32'h0, 0);
      xfer(1, 1, 0, BASE,          32'h0,        4'hF, 32'h55AA55AA, 0);
      xfer(1, 1, 0, 32'h00000000,  32'h0,        4'hF, 32'h0, 0);
      xfer(1, 1, 0, BASE,          32'h0,        4'hF, 32'h55AA55AA, 0);
      xfer(1, 1, 0, BASE + 32'h1000, 32'h0,      4'hF, 32'h0, 0);
      // Last word of the window.
      xfer(1, 0, 1, BASE + 32'hFFC, 32'h0F0F0F0F, 4'hF, 32'h0, 0);
      xfer(1, 1, 0, BASE + 32'hFFC, 32'h0,        4'hF, 32'h0F0F0F0F, 0);

      // Read and write together behave as a write returning zero.
      xfer(1, 1, 1, BASE + 32'h10, 32'h01010101, 4'hF, 32'h0, 0);
      xfer(1, 1, 0, BASE + 32'h10, 32'h0,        4'hF, 32'h01010101, 0);

      // WAIT_CYCLES=1: back-to-back reads with memread held continuously.
      xfer(0, 0, 1, BASE + 32'h100, 32'hA0A0A0A0, 4'hF, 32'h0, 0);
      xfer(0, 0, 1, BASE + 32'h104, 32'hB1B1B1B1, 4'hF, 32'h0, 0);
      xfer(0, 0, 1, BASE + 32'h108, 32'hC2C2C2C2, 4'hF, 32'h0, 0);
      xfer(0, 1, 0, BASE + 32'h100, 32'h0, 4'hF, 32'hA0A0A0A0, 1);
      xfer(0, 1, 0, BASE + 32'h104, 32'h0, 4'hF, 32'hB1B1B1B1, 1);
      xfer(0, 1, 0, BASE + 32'h108, 32'h0, 4'hF, 32'hC2C2C2C2, 0);

      // WAIT_CYCLES=3: reset during the second wait cycle of a write.
      xfer(2, 0, 1, BASE + 32'h200, 32'h01020304, 4'hF, 32'h0, 0);
      xfer(2, 1, 0, BASE + 32'h200, 32'h0,        4'hF, 32'h01020304, 0);
      sel = 2; wr = 1'b1; addr = BASE + 32'h200; wdata = 32'hCAFEF00D; be = 4'hF;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("abort_rdata_held", rdq[2], 32'h01020304);
      rst = 1'b0;
      #1;
      check("abort_rdata_reset", rdq[2], 32'h0);
      check("abort_waitrequest", 32'(wq[2]), 32'h1);
      @(negedge clk);
      check("abort_rdata_in_reset", rdq[2], 32'h0);
      wr = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      xfer(2, 1, 0, BASE + 32'h200, 32'h0, 4'hF, 32'h01020304, 0);

      repeat (4) @(posedge clk);
      check("queue_drained", 32'(q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
